// File: rtl/calc_pkg.sv
// Shared types for the calculator button sequencer: FSM states and the legal opcode set.
package calc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Opcode that produces each {btnl,btnc,btnr} code
   localparam logic [3:0] OP_B000 = 4'b0000;
   localparam logic [3:0] OP_B001 = 4'b0001;
   localparam logic [3:0] OP_B010 = 4'b0010;
   localparam logic [3:0] OP_B011 = 4'b0110;
   localparam logic [3:0] OP_B100 = 4'b0100;
   localparam logic [3:0] OP_B101 = 4'b1001;
   localparam logic [3:0] OP_B110 = 4'b1010;
   localparam logic [3:0] OP_B111 = 4'b0101;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/calc_btn_dec.sv
// Combinational opcode -> {btnl,btnc,btnr} decode with a legal flag.
module calc_btn_dec
   import calc_pkg::*;
(
   input  logic [3:0] op,
   output logic [2:0] btn,
   output logic       legal
);

   always_comb begin
      btn   = 3'b000;
      legal = 1'b1;
      case (op)
         OP_B000: btn = 3'b000;
         OP_B001: btn = 3'b001;
         OP_B010: btn = 3'b010;
         OP_B011: btn = 3'b011;
         OP_B100: btn = 3'b100;
         OP_B101: btn = 3'b101;
         OP_B110: btn = 3'b110;
         OP_B111: btn = 3'b111;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/calc_btn_seq.sv
// Button sequencer: holds decoded button levels for HOLD_CYCLES, then GAP_CYCLES low.
// Define CALC_SEQ_QUEUE_EN to add a one-entry opcode buffer accepted while busy.
//
// state | meaning
// IDLE  | waiting for an opcode, buttons low
// HOLD  | decoded buttons driven, counter runs down
// GAP   | buttons low between presses, counter runs down
module calc_btn_seq
   import calc_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] op_in,
   input  logic       op_valid,
   output logic       op_ready,
   output logic       btnl,
   output logic       btnc,
   output logic       btnr,
   output logic       busy,
   output logic       err
);

   localparam int CNT_MAX = max_int(HOLD_CYCLES, GAP_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       btn_q, btn_d;
   logic             err_q, err_d;
   logic             ready_en_q;
   logic             xfer;
   logic [3:0]       dec_op;
   logic [2:0]       dec_btn;
   logic             dec_legal;

`ifdef CALC_SEQ_QUEUE_EN
   logic             q_valid_q, q_valid_d;
   logic [3:0]       q_op_q, q_op_d;

   assign op_ready = ready_en_q && ((state_q == IDLE) || !q_valid_q);
   // A buffered opcode takes priority; the buffer blocks new transfers while full
   assign dec_op   = q_valid_q ? q_op_q : op_in;
`else
   assign op_ready = ready_en_q && (state_q == IDLE);
   assign dec_op   = op_in;
`endif

   assign xfer = op_valid && op_ready;

   calc_btn_dec u_dec (
      .op    (dec_op),
      .btn   (dec_btn),
      .legal (dec_legal)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      btn_d   = btn_q;
      err_d   = 1'b0;
`ifdef CALC_SEQ_QUEUE_EN
      q_valid_d = q_valid_q;
      q_op_d    = q_op_q;
`endif
      case (state_q)
         IDLE: begin
            if (xfer) begin
               if (dec_legal) begin
                  state_d = HOLD;
                  cnt_d   = HOLD_LOAD;
                  btn_d   = dec_btn;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               state_d = GAP;
               cnt_d   = GAP_LOAD;
               btn_d   = 3'b000;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               state_d = IDLE;
               cnt_d   = '0;
               btn_d   = 3'b000;
`ifdef CALC_SEQ_QUEUE_EN
               // Chain straight into the next press from the last gap cycle
               if (q_valid_q || xfer) begin
                  q_valid_d = 1'b0;
                  if (dec_legal) begin
                     state_d = HOLD;
                     cnt_d   = HOLD_LOAD;
                     btn_d   = dec_btn;
                  end else begin
                     err_d = 1'b1;
                  end
               end
`endif
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            btn_d   = 3'b000;
         end
      endcase
`ifdef CALC_SEQ_QUEUE_EN
      if (xfer && (state_q != IDLE) && !((state_q == GAP) && (cnt_q == '0))) begin
         q_valid_d = 1'b1;
         q_op_d    = op_in;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         btn_q      <= 3'b000;
         err_q      <= 1'b0;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         btn_q      <= btn_d;
         err_q      <= err_d;
         ready_en_q <= 1'b1;
      end
   end

`ifdef CALC_SEQ_QUEUE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_valid_q <= 1'b0;
         q_op_q    <= 4'b0000;
      end else begin
         q_valid_q <= q_valid_d;
         q_op_q    <= q_op_d;
      end
   end
`endif

   assign {btnl, btnc, btnr} = btn_q;
   assign busy               = (state_q != IDLE);
   assign err                = err_q;

endmodule

// File: tb/tb_calc_btn_seq.sv
// Scoreboard bench for calc_btn_seq: a timeline model schedules expected outputs per cycle.
module tb_calc_btn_seq;

   localparam int H = 4;
   localparam int G = 2;

`ifdef CALC_SEQ_QUEUE_EN
   localparam bit QUEUE_EN = 1'b1;
`else
   localparam bit QUEUE_EN = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [3:0] op_in;
   logic       op_valid;
   logic       op_ready;
   logic       btnl, btnc, btnr, busy, err;

   calc_btn_seq #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .op_in    (op_in),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .btnl     (btnl),
      .btnc     (btnc),
      .btnr     (btnr),
      .busy     (busy),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [4:0] v;   // {btnl,btnc,btnr,busy,err}
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;

   // Model: cycle at which the block next becomes idle, last cycle the buffer is occupied,
   // and first cycle op_ready may rise after reset.
   int free_at    = 1 << 30;
   int buf_until  = -1;
   int ready_from = 1 << 30;
   int codes [8]  = '{0, 1, 2, 6, 4, 9, 10, 5};

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
   endtask

   function automatic int btn_of(input logic [3:0] op);
      for (int i = 0; i < 8; i++) if (codes[i] == int'(op)) return i;
      return -1;
   endfunction

   function automatic bit model_ready(input int c);
      if (c < ready_from) return 1'b0;
      if (QUEUE_EN) return c > buf_until;
      return c >= free_at;
   endfunction

   task automatic schedule(input int n, input logic [3:0] op);
      int s;
      int b;
      exp_t e;
      s = (n >= free_at) ? n : free_at - 1;
      if (s > n) buf_until = s;
      b = btn_of(op);
      if (b < 0) begin
         e.cyc = s + 1; e.v = 5'b00001; sb.push_back(e);
      end else begin
         for (int k = 1; k <= H; k++) begin
            e.cyc = s + k; e.v = {b[2:0], 2'b10}; sb.push_back(e);
         end
         for (int k = 1; k <= G; k++) begin
            e.cyc = s + H + k; e.v = 5'b00010; sb.push_back(e);
         end
         free_at = s + 1 + H + G;
      end
   endtask

   // Monitor: every cycle the outputs must match the scheduled entry, or idle zeros.
   always @(negedge clk) begin
      logic [4:0] exp_v;
      exp_v = 5'b00000;
      if (sb.size() > 0 && sb[0].cyc == cyc) exp_v = sb.pop_front().v;
      check("outputs", {btnl, btnc, btnr, busy, err}, exp_v);
   end

   task automatic drive(input logic v, input logic [3:0] op);
      bit r;
      r = model_ready(cyc);
      check("op_ready", {4'b0, op_ready}, {4'b0, r});
      op_valid = v;
      op_in    = op;
      if (v && r) schedule(cyc, op);
      @(negedge clk);
   endtask

   task automatic wait_ready();
      int guard = 0;
      while (!model_ready(cyc) && guard < 50) begin
         drive(1'b0, 4'h0);
         guard++;
      end
   endtask

   task automatic apply_reset();
      op_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("reset_outputs", {btnl, btnc, btnr, busy, err}, 5'b00000);
      check("reset_ready", {4'b0, op_ready}, 5'b00000);
      repeat (2) begin
         @(negedge clk);
         check("reset_ready_held", {4'b0, op_ready}, 5'b00000);
      end
      rst_n      = 1'b1;
      ready_from = cyc + 1;
      free_at    = cyc + 1;
      buf_until  = -1;
      @(negedge clk);
   endtask

   initial begin
      rst_n    = 1'b0;
      op_valid = 1'b0;
      op_in    = 4'h0;
      repeat (3) @(negedge clk);
      rst_n      = 1'b1;
      ready_from = cyc + 1;
      free_at    = cyc + 1;
      @(negedge clk);

      // op 0110 transferred at cycle 10
      while (cyc < 10) drive(1'b0, 4'h0);
      drive(1'b1, 4'b0110);
      repeat (8) drive(1'b0, 4'h0);

      // illegal opcode
      drive(1'b1, 4'b0011);
      repeat (3) drive(1'b0, 4'h0);

      // reset during the second HOLD cycle, then op 0001
      wait_ready();
      drive(1'b1, 4'b1010);
      drive(1'b0, 4'h0);
      apply_reset();
      drive(1'b1, 4'b0001);
      repeat (8) drive(1'b0, 4'h0);

      // op_in changes while op_valid stays high during HOLD
      wait_ready();
      drive(1'b1, 4'b0001);
      repeat (10) drive(1'b1, 4'b0100);
      repeat (8) drive(1'b0, 4'h0);

      // back-to-back legal opcodes
      wait_ready();
      drive(1'b1, 4'b0101);
      drive(1'b1, 4'b1001);
      repeat (14) drive(1'b0, 4'h0);

      // sweep all 16 opcodes
      for (int op = 0; op < 16; op++) begin
         wait_ready();
         drive(1'b1, 4'(op));
      end
      repeat (10) drive(1'b0, 4'h0);

      // randomized traffic with an occasional reset
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 199) == 0) apply_reset();
         else drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
      repeat (15) drive(1'b0, 4'h0);

      check("scoreboard_drained", 5'(sb.size()), 5'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/calc_btn_seq.md
CALC_BTN_SEQ -- requirements
Module: calc_btn_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: number of cycles the decoded button levels are held (legal 1..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 2: number of all-buttons-low cycles after each hold (legal 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port op_in, input, 4 bits: requested ALU opcode.
REQ-006 SHALL have port op_valid, input, 1 bit: op_in is valid.
REQ-007 SHALL have port op_ready, output, 1 bit: block accepts op_in this cycle.
REQ-008 SHALL have ports btnl, btnc and btnr, outputs, 1 bit each: registered button levels.
REQ-009 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-010 SHALL have port err, output, 1 bit: one-cycle pulse flagging an accepted opcode with no legal button code.

Function
REQ-011 SHALL accept an opcode on any cycle where op_valid and op_ready are both 1; no other cycle is a transfer.
REQ-012 SHALL decode {btnl,btnc,btnr} as follows: 0000->000, 0001->001, 0010->010, 0110->011, 0100->100, 1001->101, 1010->110, 0101->111.
REQ-013 SHALL treat every other opcode as illegal; an accepted illegal opcode pulses err for the cycle after acceptance, drives no buttons and leaves state at IDLE.
REQ-014 SHALL use an FSM with states IDLE, HOLD and GAP: IDLE->HOLD on a legal transfer; HOLD->GAP after HOLD_CYCLES; GAP->IDLE after GAP_CYCLES, or GAP->HOLD when a queued opcode is pending (see REQ-022).
REQ-015 SHALL, for a transfer on cycle N, drive the decoded buttons on cycles N+1..N+HOLD_CYCLES exactly and drive all buttons 0 for the following GAP_CYCLES cycles.
REQ-016 SHALL drive op_ready = 1 only in IDLE when REQ-022 is not in effect.
REQ-017 SHALL use a down-counter sized by $clog2 of max(HOLD_CYCLES,GAP_CYCLES)+1; the counter SHALL never wrap.
REQ-018 SHALL accept opcode 0000 as legal: it runs a full HOLD/GAP sequence with all buttons 0 and busy = 1.
REQ-019 SHALL ignore changes to op_in and op_valid while op_ready = 0; the latched opcode is unaffected.

Reset
REQ-020 SHALL, on rst_n low at any time including mid-HOLD, immediately force state to IDLE, counter to 0, btnl/btnc/btnr to 0, busy to 0, err to 0 and clear any queued opcode.
REQ-021 SHALL drive op_ready = 0 while rst_n is low and SHALL assert it on the first clock edge after release.

Configuration
REQ-022 SHALL, with CALC_SEQ_QUEUE_EN defined, add a one-entry opcode buffer: op_ready = 1 in IDLE, or in HOLD/GAP while the buffer is empty.
REQ-023 SHALL, with CALC_SEQ_QUEUE_EN defined, go from the last GAP cycle directly to HOLD with the buffered opcode; an illegal buffered opcode pulses err on that cycle and goes to IDLE.
REQ-024 SHALL, without CALC_SEQ_QUEUE_EN, contain no buffer and behave exactly per REQ-016.

Structure
REQ-025 SHALL place the FSM state enum (IDLE, HOLD, GAP) and the eight legal opcode localparams in shared package calc_pkg.
REQ-026 SHALL implement the opcode-to-button decode as a purely combinational sub-module calc_btn_dec with outputs {btnl,btnc,btnr} and a legal flag.

Verification
REQ-027 SHALL cover: op 0110 accepted at cycle 10 -> btnc = btnr = 1, btnl = 0 on cycles 11-14; all buttons 0 on cycles 15-16; op_ready = 1 at cycle 17.
REQ-028 SHALL cover: op 0011 accepted -> err = 1 for one cycle, all buttons stay 0, busy = 0, op_ready stays 1.
REQ-029 SHALL cover: rst_n low during the 2nd HOLD cycle of op 1010 -> buttons 0 and busy 0 immediately; after release op 0001 gives btnr = 1 for 4 cycles.
REQ-030 SHALL cover: op_valid held with op_in changing 0001->0100 during HOLD (queue off) -> original buttons unchanged; 0100 transferred only when op_ready = 1.
REQ-031 SHALL cover, with CALC_SEQ_QUEUE_EN: op 0101 then 1001 back-to-back -> 111 held 4 cycles, 2 gap cycles, 101 held 4 cycles, busy never 0 in between.
REQ-032 SHALL cover: all 16 opcodes swept -> exactly the eight in REQ-012 drive buttons, the other eight each pulse err.
